// File: rtl/opl3_pkg.sv
// Shared OPL3 geometry constants.
// Bank/operator counts and the address widths derived from them.
package opl3_pkg;
  localparam int NUM_BANKS              = 2;
  localparam int NUM_OPERATORS_PER_BANK = 18;
  localparam int BANK_NUM_WIDTH         = 1;
  localparam int OP_NUM_WIDTH           = 5;
endpackage

// File: rtl/operator_slot_sequencer.sv
// Operator slot sequencer: walks all 36 operator slots once per sample frame.
// Ports: clk, reset_n; sample_clk_en (frame start); key_on_req/bank/op
// (phase restart requests); overrun_clr; bank_num/op_num (slot address);
// slot_en / slot_capture (first / last cycle of slot); key_on_pulse;
// busy / frame_done / overrun (status).
module operator_slot_sequencer
  import opl3_pkg::*;
#(
  parameter int NUM_SLOT_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_clk_en,
  input  logic                      key_on_req,
  input  logic [BANK_NUM_WIDTH-1:0] key_on_bank,
  input  logic [OP_NUM_WIDTH-1:0]   key_on_op,
  input  logic                      overrun_clr,
  output logic [BANK_NUM_WIDTH-1:0] bank_num,
  output logic [OP_NUM_WIDTH-1:0]   op_num,
  output logic                      slot_en,
  output logic                      key_on_pulse,
  output logic                      slot_capture,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int NUM_OPS = NUM_BANKS * NUM_OPERATORS_PER_BANK;
  localparam int IDX_W   = $clog2(NUM_OPS) + 1;

  if (NUM_SLOT_CYCLES < 4 || NUM_SLOT_CYCLES > 255) begin : g_bad_param
    $error("NUM_SLOT_CYCLES must be 4..255");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [BANK_NUM_WIDTH-1:0] bank_q, bank_d;
  logic [OP_NUM_WIDTH-1:0]   op_q, op_d;
  logic [NUM_OPS-1:0]        pend_q, pend_d;
  logic                      key_q, key_d;
  logic                      ovr_q, ovr_d;

  logic             run, cnt_first, cnt_last;
  logic             op_last, bank_last, final_cap;
  logic             req_ok;
  logic [IDX_W-1:0] cur_idx, req_idx;

  assign run       = (state_q == RUN);
  assign cnt_first = (cnt_q == 8'd0);
  assign cnt_last  = (cnt_q == 8'(NUM_SLOT_CYCLES - 1));
  assign op_last   = (op_q == OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1));
  assign bank_last = (bank_q == BANK_NUM_WIDTH'(NUM_BANKS - 1));
  assign final_cap = run && cnt_last && op_last && bank_last;

  assign cur_idx = IDX_W'(bank_q) * IDX_W'(NUM_OPERATORS_PER_BANK)
                 + IDX_W'(op_q);
  assign req_idx = IDX_W'(key_on_bank) * IDX_W'(NUM_OPERATORS_PER_BANK)
                 + IDX_W'(key_on_op);
  assign req_ok  = key_on_req
                && (key_on_op < OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    op_d    = op_q;
    key_d   = key_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q & ~overrun_clr;

    // Capture-and-clear first so a same-cycle request re-arms the bit.
    if (run && cnt_first) begin
      key_d           = pend_q[cur_idx];
      pend_d[cur_idx] = 1'b0;
    end
    if (req_ok) begin
      pend_d[req_idx] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sample_clk_en) begin
          state_d = RUN;
          cnt_d   = '0;
          bank_d  = '0;
          op_d    = '0;
        end
      end
      RUN: begin
        if (sample_clk_en && !final_cap) begin
          ovr_d = 1'b1;
        end
        if (!cnt_last) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = '0;
          if (final_cap) begin
            bank_d = '0;
            op_d   = '0;
            if (!sample_clk_en) begin
              state_d = IDLE;
            end
          end else if (op_last) begin
            op_d   = '0;
            bank_d = bank_q + 1'b1;
          end else begin
            op_d = op_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      op_q    <= '0;
      pend_q  <= '0;
      key_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      key_q   <= key_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bank_num     = bank_q;
  assign op_num       = op_q;
  assign busy         = run;
  assign slot_en      = run && cnt_first;
  assign slot_capture = run && cnt_last;
  assign frame_done   = final_cap;
  assign overrun      = ovr_q;
  // First slot cycle sees the pending bit directly; later cycles the copy.
  assign key_on_pulse = run && (cnt_first ? pend_q[cur_idx] : key_q);

endmodule

// File: tb/tb_operator_slot_sequencer.sv
// Testbench for operator_slot_sequencer.
// Random and directed stimulus against a slot-arithmetic reference model.
module tb_operator_slot_sequencer;

  localparam int N = 8;
  localparam int FRAME = 36 * N;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_clk_en, key_on_req, overrun_clr;
  logic       key_on_bank;
  logic [4:0] key_on_op;
  logic       bank_num;
  logic [4:0] op_num;
  logic       slot_en, key_on_pulse, slot_capture;
  logic       busy, frame_done, overrun;

  int checks = 0;
  int errors = 0;

  operator_slot_sequencer #(.NUM_SLOT_CYCLES(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_clk_en(sample_clk_en),
    .key_on_req(key_on_req),
    .key_on_bank(key_on_bank),
    .key_on_op(key_on_op),
    .overrun_clr(overrun_clr),
    .bank_num(bank_num), .op_num(op_num),
    .slot_en(slot_en),
    .key_on_pulse(key_on_pulse),
    .slot_capture(slot_capture),
    .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: frame position is a plain offset t into the frame.
  logic        m_run, m_key, m_ovr;
  int          m_t;
  logic [35:0] m_pend;
  int          e_slot, e_cnt;
  logic        e_slot_en, e_cap, e_done, e_key, e_bank;
  logic [4:0]  e_op;

  always_comb begin
    e_slot    = m_t / N;
    e_cnt     = m_t % N;
    e_slot_en = m_run && (e_cnt == 0);
    e_cap     = m_run && (e_cnt == N - 1);
    e_done    = e_cap && (e_slot == 35);
    e_bank    = m_run ? 1'(e_slot / 18) : 1'b0;
    e_op      = m_run ? 5'(e_slot % 18) : 5'd0;
    e_key     = m_run && ((e_cnt == 0) ? m_pend[e_slot] : m_key);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run  <= 1'b0;
      m_t    <= 0;
      m_pend <= '0;
      m_key  <= 1'b0;
      m_ovr  <= 1'b0;
    end else begin
      automatic logic [35:0] p = m_pend;
      m_ovr <= (m_ovr && !overrun_clr)
            || (m_run && sample_clk_en && !e_done);
      if (e_slot_en) begin
        m_key     <= p[e_slot];
        p[e_slot] = 1'b0;
      end
      if (key_on_req && key_on_op < 5'd18)
        p[int'(key_on_bank) * 18 + int'(key_on_op)] = 1'b1;
      m_pend <= p;
      if (!m_run) begin
        if (sample_clk_en) begin
          m_run <= 1'b1;
          m_t   <= 0;
        end
      end else if (e_done) begin
        m_run <= sample_clk_en;
        m_t   <= 0;
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  logic [11:0] act, exp_v;
  assign act = {bank_num, op_num, slot_en, key_on_pulse,
                slot_capture, busy, frame_done, overrun};
  assign exp_v = {e_bank, e_op, e_slot_en, e_key,
                  e_cap, m_run, e_done, m_ovr};

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_ovr;
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
  endtask

  task automatic req(input logic b, input logic [4:0] o);
    key_on_req  = 1'b1;
    key_on_bank = b;
    key_on_op   = o;
    tick;
    key_on_req  = 1'b0;
  endtask

  // Runs one frame from IDLE; counts key pulse cycles per slot and
  // cycles where the DUT disagreed with the model.
  task automatic run_frame(input int inj_at, input logic ib,
                           input logic [4:0] io, output int kp[36],
                           output int done_at, output int mism);
    kp = '{default: 0};
    done_at = -1;
    mism = 0;
    sample_clk_en = 1'b1;
    for (int i = 1; i <= FRAME + 12; i++) begin
      tick;
      sample_clk_en = 1'b0;
      key_on_req = 1'b0;
      if (act !== exp_v) mism++;
      if (key_on_pulse === 1'b1 && i <= FRAME) kp[(i - 1) / N]++;
      if (frame_done === 1'b1 && done_at < 0) done_at = i;
      if (i == inj_at) begin
        key_on_req  = 1'b1;
        key_on_bank = ib;
        key_on_op   = io;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick;
    checks++;
    if (act !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=000", act);
    end
    reset_n = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_single_frame;
    int k = 0;
    int done_at = -1;
    sample_clk_en = 1'b1;
    for (int i = 1; i <= FRAME + 10; i++) begin
      tick;
      sample_clk_en = 1'b0;
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL frame_cycle%0d got=%h exp=%h", i, act, exp_v);
      end
      if (slot_en === 1'b1) begin
        checks++;
        if ({bank_num, op_num} !== {1'(k / 18), 5'(k % 18)}) begin
          errors++;
          $display("FAIL slot_addr%0d got=%0d/%0d exp=%0d/%0d",
                   k, bank_num, op_num, k / 18, k % 18);
        end
        k++;
      end
      if (frame_done === 1'b1) done_at = i;
    end
    checks++;
    if (k != 36) begin
      errors++;
      $display("FAIL slot_en_count got=%0d exp=36", k);
    end
    checks++;
    if (done_at != 288) begin
      errors++;
      $display("FAIL frame_done_cycle got=%0d exp=288", done_at);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_frame got=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int seen = 0;
    clr_ovr;
    sample_clk_en = 1'b1;
    tick;
    sample_clk_en = 1'b0;
    for (int i = 0; i < FRAME + 10 && seen == 0; i++) begin
      if (frame_done === 1'b1) seen = 1;
      else tick;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL b2b_wait_done got=timeout exp=frame_done");
    end
    sample_clk_en = 1'b1;
    tick;
    sample_clk_en = 1'b0;
    checks++;
    if ({slot_en, busy, bank_num, op_num, overrun} !== 9'b1_1_0_00000_0) begin
      errors++;
      $display("FAIL b2b_restart got=%b%b%b%h%b exp=11000",
               slot_en, busy, bank_num, op_num, overrun);
    end
    seen = 0;
    for (int i = 0; i < FRAME + 10 && seen == 0; i++) begin
      if (frame_done === 1'b1) seen = 1;
      tick;
    end
    checks++;
    if ({seen[0], busy, overrun} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_end got=%b%b%b exp=100", seen[0], busy, overrun);
    end
  endtask

  task automatic test_overrun;
    int done_at = -1;
    clr_ovr;
    sample_clk_en = 1'b1;
    for (int i = 1; i <= FRAME + 10; i++) begin
      tick;
      sample_clk_en = (i == 100);
      if (frame_done === 1'b1) done_at = i;
      if (i == 101) begin
        checks++;
        if ({overrun, busy} !== 2'b11) begin
          errors++;
          $display("FAIL ovr_set got=%b%b exp=11", overrun, busy);
        end
      end
    end
    checks++;
    if (done_at != 288) begin
      errors++;
      $display("FAIL ovr_frame_done got=%0d exp=288", done_at);
    end
    checks++;
    if ({overrun, busy} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_sticky got=%b%b exp=10", overrun, busy);
    end
    sample_clk_en = 1'b1;
    tick;
    sample_clk_en = 1'b0;
    repeat (5) tick;
    sample_clk_en = 1'b1;
    overrun_clr   = 1'b1;
    tick;
    sample_clk_en = 1'b0;
    overrun_clr   = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_and_clr got=%b exp=1", overrun);
    end
    clr_ovr;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got=%b exp=0", overrun);
    end
    for (int i = 0; i < FRAME + 10 && busy === 1'b1; i++) tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_wait_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_key_on;
    int kp[36];
    int d, m, sum;
    req(1'b1, 5'd5);
    run_frame(0, 1'b0, 5'd0, kp, d, m);
    sum = kp.sum();
    checks++;
    if (kp[23] != 8 || sum != 8 || m != 0) begin
      errors++;
      $display("FAIL key_on_slot got=%0d total=%0d mism=%0d exp=8/8/0",
               kp[23], sum, m);
    end
    run_frame(0, 1'b0, 5'd0, kp, d, m);
    sum = kp.sum();
    checks++;
    if (sum != 0 || m != 0) begin
      errors++;
      $display("FAIL key_on_next got=%0d mism=%0d exp=0/0", sum, m);
    end
  endtask

  task automatic test_collision;
    int kp[36];
    int d, m, sum;
    req(1'b0, 5'd3);
    run_frame(25, 1'b0, 5'd3, kp, d, m);
    checks++;
    if (kp[3] != 8 || m != 0) begin
      errors++;
      $display("FAIL coll_first got=%0d mism=%0d exp=8/0", kp[3], m);
    end
    run_frame(0, 1'b0, 5'd0, kp, d, m);
    sum = kp.sum();
    checks++;
    if (kp[3] != 8 || sum != 8 || m != 0) begin
      errors++;
      $display("FAIL coll_second got=%0d total=%0d exp=8/8", kp[3], sum);
    end
    req(1'b0, 5'd20);
    run_frame(0, 1'b0, 5'd0, kp, d, m);
    sum = kp.sum();
    checks++;
    if (sum != 0 || m != 0) begin
      errors++;
      $display("FAIL coll_badop got=%0d mism=%0d exp=0/0", sum, m);
    end
  endtask

  task automatic test_reset_midframe;
    int kp[36];
    int d, m, sum;
    int bad = 0;
    req(1'b1, 5'd1);
    sample_clk_en = 1'b1;
    for (int i = 1; i <= 73; i++) begin
      tick;
      sample_clk_en = 1'b0;
    end
    checks++;
    if ({slot_en, bank_num, op_num} !== {1'b1, 1'b0, 5'd9}) begin
      errors++;
      $display("FAIL rst_pos got=%b/%0d/%0d exp=1/0/9",
               slot_en, bank_num, op_num);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (act !== 12'h000) begin
      errors++;
      $display("FAIL rst_async got=%h exp=000", act);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_no_done got=%0d exp=0", bad);
    end
    run_frame(0, 1'b0, 5'd0, kp, d, m);
    sum = kp.sum();
    checks++;
    if (sum != 0 || d != 288 || m != 0) begin
      errors++;
      $display("FAIL rst_new_frame got=%0d/%0d/%0d exp=0/288/0",
               sum, d, m);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 4000; i++) begin
      sample_clk_en = ($urandom_range(0, 39) == 0);
      key_on_req    = ($urandom_range(0, 3) == 0);
      key_on_bank   = 1'($urandom_range(0, 1));
      key_on_op     = 5'($urandom_range(0, 23));
      overrun_clr   = ($urandom_range(0, 19) == 0);
      tick;
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d got=%h exp=%h", i, act, exp_v);
      end
    end
    sample_clk_en = 1'b0;
    key_on_req    = 1'b0;
    overrun_clr   = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    sample_clk_en = 1'b0;
    key_on_req    = 1'b0;
    key_on_bank   = 1'b0;
    key_on_op     = 5'd0;
    overrun_clr   = 1'b0;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overrun;
    test_key_on;
    test_collision;
    test_reset_midframe;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operator_slot_sequencer.md
OPERATOR_SLOT_SEQUENCER -- requirements
Module: operator_slot_sequencer

Interface
REQ-001 Parameter NUM_SLOT_CYCLES, default 8, clocks per operator slot; SHALL be legal only for values 4..255.
REQ-002 Parameters NUM_BANKS (2) and NUM_OPERATORS_PER_BANK (18), and widths BANK_NUM_WIDTH (1) and OP_NUM_WIDTH (5), SHALL be taken from opl3_pkg.
REQ-003 clk  in  1  sole clock; all state SHALL change only on posedge clk.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sample_clk_en  in  1  one-cycle frame start request, once per output sample.
REQ-006 key_on_req  in  1  one-cycle request to restart the phase of one operator.
REQ-007 key_on_bank / key_on_op  in  BANK_NUM_WIDTH / OP_NUM_WIDTH  target of key_on_req.
REQ-008 overrun_clr  in  1  clears the sticky overrun flag.
REQ-009 bank_num / op_num  out  BANK_NUM_WIDTH / OP_NUM_WIDTH  current slot address, registered.
REQ-010 slot_en  out  1  one-cycle pulse in the first cycle of each slot (drives phase_generator sample_clk_en).
REQ-011 key_on_pulse  out  1  level held for the whole slot when that operator has a pending key-on.
REQ-012 slot_capture  out  1  one-cycle pulse in the last cycle of each slot (operator output valid).
REQ-013 busy / frame_done / overrun  out  1 / 1 / 1  frame in progress / end-of-frame pulse / sticky error.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-015 In IDLE, sample_clk_en=1 SHALL cause a transition to RUN next cycle with bank_num=0, op_num=0, slot counter=0.
REQ-016 In RUN, the slot counter SHALL increment each cycle from 0 to NUM_SLOT_CYCLES-1 and then wrap to 0 while the address advances.
REQ-017 Address order SHALL be op 0..17 of bank 0, then op 0..17 of bank 1; a frame is 36 slots of 36*NUM_SLOT_CYCLES cycles (288 at default).
REQ-018 slot_en SHALL be 1 only when in RUN and counter==0.
REQ-019 slot_capture SHALL be 1 only when in RUN and counter==NUM_SLOT_CYCLES-1.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 frame_done SHALL pulse in the same cycle as slot_capture of bank 1, op 17; the FSM SHALL return to IDLE next cycle.
REQ-022 If sample_clk_en=1 in that final-capture cycle, it SHALL be accepted without overrun and RUN SHALL restart at bank 0, op 0, counter 0 with no idle cycle.
REQ-023 sample_clk_en=1 in any other RUN cycle SHALL be ignored for sequencing and SHALL set overrun.
REQ-024 overrun SHALL remain set until overrun_clr=1, which clears it next cycle; a simultaneous set and clear SHALL leave overrun=1.
REQ-025 A 36-bit pending bitmap, indexed bank*18+op, SHALL be set by key_on_req at the addressed bit.
REQ-026 key_on_req with key_on_op>17 SHALL be ignored.
REQ-027 At each slot start (slot_en cycle), the pending bit of the current operator SHALL be copied into a register that drives key_on_pulse for that slot, and the bit SHALL be cleared.
REQ-028 If key_on_req targets the same bit in the same cycle it is cleared, the set SHALL win and the request SHALL be delivered in the next frame.
REQ-029 key_on_req SHALL be accepted in both IDLE and RUN.
REQ-030 In IDLE, bank_num and op_num SHALL hold 0, and key_on_pulse, slot_en and slot_capture SHALL be 0.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, counter=0, bank_num=0, op_num=0, pending bitmap=0, and all 1-bit outputs=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after release, the block SHALL wait for a new sample_clk_en.
REQ-033 The first sample_clk_en SHALL be honoured when it arrives at least one cycle after reset_n deasserts.

Verification
REQ-034 Single frame, NUM_SLOT_CYCLES=8: one sample_clk_en -> 36 slot_en pulses spaced 8 cycles apart, addresses (0,0)..(1,17) in order, frame_done at cycle 288 after the start, busy low afterwards.
REQ-035 Back-to-back frames: sample_clk_en exactly in the frame_done cycle -> next slot_en (0,0) the following cycle, overrun stays 0.
REQ-036 Overrun: sample_clk_en at cycle 100 of a frame -> frame unaffected, overrun=1 until overrun_clr; overrun_clr and a new overrun in the same cycle -> overrun=1.
REQ-037 Key-on: key_on_req (1,5) in IDLE -> key_on_pulse high for all 8 cycles of slot (1,5) only; absent in the next frame.
REQ-038 Key-on collision: key_on_req (0,3) in the slot_en cycle of (0,3) with the bit already pending -> pulse in this frame and again in the next frame; key_on_op=20 -> no effect.
REQ-039 Reset mid-frame: reset_n low at slot (0,9) -> all outputs 0 immediately, pending bitmap cleared, no frame_done; a new sample_clk_en starts at (0,0).
